// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: host command opcodes, TAP instruction codes and
// the tms header patterns the driver walks the TAP with.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_SHIFT_IR = 2'd1,
    OP_SHIFT_DR = 2'd2,
    OP_IDLE     = 2'd3
  } jtag_op_e;

  localparam logic [4:0] INSTR_BYPASS  = 5'b11111;
  localparam logic [4:0] INSTR_IDCODE  = 5'b00001;
  localparam logic [4:0] INSTR_SAMPLE  = 5'b00010;
  localparam logic [4:0] INSTR_PRELOAD = 5'b00011;
  localparam logic [4:0] INSTR_INTEST  = 5'b00100;
  localparam logic [4:0] INSTR_EXTEST  = 5'b00101;
  localparam logic [4:0] INSTR_BIST    = 5'b00111;

  localparam logic [31:0] IDCODE_VALUE = 32'hDEADBEEF;
  localparam int          IR_LEN       = 5;
  localparam int          BSR_LEN      = 10;

  // Header tms patterns, LSB is the first slot.
  localparam logic [6:0] HDR_TMS_RESET   = 7'b0111111;
  localparam logic [6:0] HDR_TMS_IR      = 7'b0000011;
  localparam logic [6:0] HDR_TMS_DR      = 7'b0000001;
  localparam int         HDR_SLOTS_RESET = 7;
  localparam int         HDR_SLOTS_IR    = 4;
  localparam int         HDR_SLOTS_DR    = 3;

endpackage

// File: rtl/jtag_tck_gen.sv
// tck divider: tck low then high for CLK_DIV clk cycles each while enabled.
// Strobes flag the clk cycle whose closing edge raises or lowers tck.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int              PH_W   = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            tck_q, tck_d;
  logic            wrap;

  always_comb begin
    wrap     = en && (phase_q == PH_MAX);
    rise_stb = wrap && !tck_q;
    fall_stb = wrap && tck_q;
    phase_d  = '0;
    tck_d    = 1'b0;
    if (en) begin
      phase_d = wrap ? '0 : phase_q + 1'b1;
      tck_d   = wrap ? ~tck_q : tck_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      tck_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      tck_q   <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG host driver: turns parallel RESET / SHIFT_IR / SHIFT_DR / IDLE commands
// into tck/tms/tdi slot sequences and returns the captured tdo bits.
//
// state   | meaning
// S_IDLE  | waiting for a command, tck parked low
// S_HDR   | header tms slots (whole sequence for RESET and IDLE)
// S_SHIFT | data slots, tms=1 on the last one
// S_TRL   | trailer tms 1,0 back to Run-Test/Idle
// S_DONE  | rsp_valid pulse, may accept the next command
module jtag_host_driver
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TRL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);

  logic [2:0]         state_q, state_d;
  jtag_op_e           op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         hdr_q, hdr_d;
  logic [MAX_LEN-1:0] dat_q, dat_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               en_q, en_d;

  logic               fall_stb, rise_stb;
  logic               accept, is_shift, cmd_is_shift;
  jtag_op_e           cmd_op_e;
  logic [LEN_W-1:0]   len_c;
  logic [6:0]         hdr_pat;
  logic [LEN_W-1:0]   hdr_len;

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    cmd_op_e     = jtag_op_e'(cmd_op);
    len_c        = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    cmd_is_shift = (cmd_op_e == OP_SHIFT_IR) || (cmd_op_e == OP_SHIFT_DR);
    hdr_pat      = '0;
    hdr_len      = LEN_ONE;
    case (cmd_op_e)
      OP_RESET: begin
        hdr_pat = HDR_TMS_RESET;
        hdr_len = LEN_W'(HDR_SLOTS_RESET);
      end
      OP_SHIFT_IR: begin
        hdr_pat = HDR_TMS_IR;
        hdr_len = LEN_W'(HDR_SLOTS_IR);
      end
      OP_SHIFT_DR: begin
        hdr_pat = HDR_TMS_DR;
        hdr_len = LEN_W'(HDR_SLOTS_DR);
      end
      default: begin
        hdr_pat = '0;
        hdr_len = (len_c == '0) ? LEN_ONE : len_c;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    dat_d    = dat_q;
    cap_d    = cap_q;
    rsp_d    = rsp_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    en_d     = en_q;
    accept   = cmd_valid && cmd_ready;
    is_shift = (op_q == OP_SHIFT_IR) || (op_q == OP_SHIFT_DR);

    // Captured bits enter at the MSB; the response is right-aligned by length later.
    if (rise_stb && (state_q == S_SHIFT)) begin
      cap_d = {tdo, cap_q[MAX_LEN-1:1]};
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_HDR;
          op_d    = cmd_op_e;
          len_d   = len_c;
          cnt_d   = hdr_len;
          hdr_d   = hdr_pat;
          dat_d   = cmd_data;
          tdi_d   = 1'b0;
          if (cmd_is_shift && (len_c == '0)) begin
            en_d = 1'b0;
          end else begin
            en_d  = 1'b1;
            tms_d = hdr_pat[0];
          end
        end
      end
      S_HDR: begin
        if (!en_q) begin
          state_d = S_DONE;
        end else if (fall_stb) begin
          if (cnt_q == LEN_ONE) begin
            if (is_shift) begin
              state_d = S_SHIFT;
              cnt_d   = len_q;
              tms_d   = (len_q == LEN_ONE);
              tdi_d   = dat_q[0];
            end else begin
              state_d = S_DONE;
              en_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - LEN_ONE;
            hdr_d = hdr_q >> 1;
            tms_d = hdr_d[0];
          end
        end
      end
      S_SHIFT: begin
        if (fall_stb) begin
          if (cnt_q == LEN_ONE) begin
            state_d = S_TRL;
            cnt_d   = LEN_TWO;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
            dat_d = dat_q >> 1;
            tdi_d = dat_d[0];
            tms_d = (cnt_q == LEN_TWO);
          end
        end
      end
      S_TRL: begin
        if (fall_stb) begin
          if (cnt_q == LEN_ONE) begin
            state_d = S_DONE;
            en_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - LEN_ONE;
            tms_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      rsp_d = is_shift ? (cap_q >> (LEN_MAX - len_q)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_RESET;
      len_q   <= '0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      dat_q   <= '0;
      cap_q   <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      dat_q   <= dat_d;
      cap_q   <= cap_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      en_q    <= en_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy      = (state_q == S_HDR) || (state_q == S_SHIFT) || (state_q == S_TRL);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_data  = rsp_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// Bench for jtag_host_driver driving a behavioural TAP (IDCODE / BYPASS).
module tb_jtag_host_driver;
  import jtag_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int NV      = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               trst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_host_driver #(
    .CLK_DIV (CLK_DIV),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  // Behavioural TAP: 16-state controller, 5-bit IR capturing 00001,
  // IDCODE data register, every other instruction acts as BYPASS.
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_st_e;

  tap_st_e     tap_st;
  logic [4:0]  tap_ir, tap_ir_sr;
  logic [31:0] tap_dr_sr;

  function automatic tap_st_e tap_next(input tap_st_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck or posedge trst) begin
    if (trst) begin
      tap_st    <= TLR;
      tap_ir_sr <= '0;
      tap_dr_sr <= '0;
    end else begin
      case (tap_st)
        CAP_IR: tap_ir_sr <= 5'b00001;
        SH_IR:  tap_ir_sr <= {tdi, tap_ir_sr[4:1]};
        CAP_DR: tap_dr_sr <= (tap_ir == INSTR_IDCODE) ? IDCODE_VALUE : 32'h0;
        SH_DR: begin
          if (tap_ir == INSTR_IDCODE) tap_dr_sr <= {tdi, tap_dr_sr[31:1]};
          else                        tap_dr_sr <= {31'h0, tdi};
        end
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck or posedge trst) begin
    if (trst) begin
      tap_ir <= INSTR_IDCODE;
      tdo    <= 1'b0;
    end else begin
      if (tap_st == TLR)    tap_ir <= INSTR_IDCODE;
      if (tap_st == UPD_IR) tap_ir <= tap_ir_sr;
      tdo <= (tap_st == SH_IR) ? tap_ir_sr[0] :
             (tap_st == SH_DR) ? tap_dr_sr[0] : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command at a negedge and follow it to its response.
  task automatic run_cmd(input jtag_op_e op, input logic [LEN_W-1:0] len,
                         input logic [31:0] data,
                         output logic [31:0] rsp, output int rises, output int npulse,
                         output int lat, output logic [6:0] tms_first, output int tbad,
                         output logic held, output logic done,
                         output logic busy1, output logic ready1, output logic ready_rsp);
    logic prev_tck;
    int   run;
    rsp = '0; rises = 0; npulse = 0; lat = -1; tms_first = '0; tbad = 0;
    held = 1'b0; done = 1'b0; busy1 = 1'b0; ready1 = 1'b1; ready_rsp = 1'b0;
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    prev_tck = tck;
    run = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    busy1  = busy;
    ready1 = cmd_ready;
    for (int c = 1; c < 2000; c++) begin
      if (tck != prev_tck) begin
        if (run != CLK_DIV) tbad++;
        if (tck) begin
          if (rises < 7) tms_first[rises] = tms;
          rises++;
        end
        run = 1;
      end else begin
        run++;
      end
      prev_tck = tck;
      if (rsp_valid) begin
        npulse++;
        if (!done) begin
          done = 1'b1;
          lat = c;
          rsp = rsp_data;
          ready_rsp = cmd_ready;
        end
      end
      if (done && (c >= lat + 4)) break;
      @(negedge clk);
    end
    held = (rsp_data === rsp);
  endtask

  typedef struct {
    jtag_op_e         op;
    logic [LEN_W-1:0] len;
    logic [31:0]      data;
    logic [31:0]      exp_rsp;
    int               exp_rises;
    int               exp_lat;
  } vec_t;

  vec_t vecs [NV];

  logic [31:0] r_rsp;
  int          r_rises, r_npulse, r_lat, r_tbad;
  logic [6:0]  r_tms;
  logic        r_held, r_done, r_busy1, r_ready1, r_ready_rsp;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "bench time limit");
  end

  initial begin
    int          acc, rsp_n, busy_ready;
    int          acc_cyc [2];
    int          rsp_cyc [2];
    logic [31:0] rsp_val [2];
    int          guard, rv_in_rst;

    vecs[0]  = '{OP_RESET,    6'd0,  32'h0,        32'h0,        7,  -1};
    vecs[1]  = '{OP_SHIFT_IR, 6'd5,  32'h0000001F, 32'h00000001, 11, -1};
    vecs[2]  = '{OP_SHIFT_DR, 6'd8,  32'h000000A5, 32'h0000004A, 13, -1};
    vecs[3]  = '{OP_RESET,    6'd0,  32'h0,        32'h0,        7,  -1};
    vecs[4]  = '{OP_SHIFT_DR, 6'd32, 32'h0,        32'hDEADBEEF, 37, -1};
    vecs[5]  = '{OP_IDLE,     6'd3,  32'h0,        32'h0,        3,  -1};
    vecs[6]  = '{OP_IDLE,     6'd0,  32'h0,        32'h0,        1,  -1};
    vecs[7]  = '{OP_SHIFT_DR, 6'd0,  32'h0000FFFF, 32'h0,        0,  2};
    vecs[8]  = '{OP_SHIFT_DR, 6'd40, 32'h0,        32'hDEADBEEF, 37, -1};
    vecs[9]  = '{OP_SHIFT_DR, 6'd16, 32'h00001234, 32'h0000BEEF, 21, -1};
    vecs[10] = '{OP_SHIFT_IR, 6'd5,  32'h0000001F, 32'h00000001, 11, -1};
    vecs[11] = '{OP_SHIFT_DR, 6'd1,  32'h00000001, 32'h0,        6,  -1};
    vecs[12] = '{OP_SHIFT_DR, 6'd8,  32'h000000FF, 32'h000000FE, 13, -1};

    rst = 1'b1; trst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset tck", tck, 1'b0);
    chk("reset tms", tms, 1'b1);
    chk("reset tdi", tdi, 1'b0);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_data", rsp_data, 32'h0);
    rst = 1'b0; trst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, r_rsp, r_rises, r_npulse, r_lat,
              r_tms, r_tbad, r_held, r_done, r_busy1, r_ready1, r_ready_rsp);
      chk($sformatf("v%0d response seen", i), r_done, 1'b1);
      chk($sformatf("v%0d rsp_data", i), r_rsp, vecs[i].exp_rsp);
      chk($sformatf("v%0d tck rises", i), r_rises, vecs[i].exp_rises);
      chk($sformatf("v%0d rsp_valid pulses", i), r_npulse, 1);
      chk($sformatf("v%0d tck half periods", i), r_tbad, 0);
      chk($sformatf("v%0d rsp_data hold", i), r_held, 1'b1);
      chk($sformatf("v%0d busy after accept", i), r_busy1, 1'b1);
      chk($sformatf("v%0d ready after accept", i), r_ready1, 1'b0);
      chk($sformatf("v%0d ready with rsp", i), r_ready_rsp, 1'b1);
      if (vecs[i].exp_lat >= 0)
        chk($sformatf("v%0d latency", i), r_lat, vecs[i].exp_lat);
      if (vecs[i].op == OP_RESET)
        chk($sformatf("v%0d reset tms", i), r_tms, 7'b0111111);
      repeat (2) @(negedge clk);
    end

    // Held cmd_valid across a BYPASS DR shift; data changes while busy.
    acc = 0; rsp_n = 0; busy_ready = 0;
    acc_cyc = '{-1, -1}; rsp_cyc = '{-1, -2}; rsp_val = '{32'h0, 32'h0};
    cmd_op = OP_SHIFT_DR; cmd_len = 6'd32; cmd_data = 32'h0F0F1234; cmd_valid = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ((acc == 1) && (c == acc_cyc[0] + 1)) cmd_data = 32'h80000001;
      if ((acc == 2) && (c == acc_cyc[1] + 1)) cmd_valid = 1'b0;
      if (busy && cmd_ready) busy_ready++;
      if (cmd_valid && cmd_ready) begin
        if (acc < 2) acc_cyc[acc] = c;
        acc++;
      end
      if (rsp_valid) begin
        if (rsp_n < 2) begin
          rsp_cyc[rsp_n] = c;
          rsp_val[rsp_n] = rsp_data;
        end
        rsp_n++;
      end
      if (rsp_n >= 2) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("hold accepts", acc, 2);
    chk("hold responses", rsp_n, 2);
    chk("hold 2nd accept at rsp", acc_cyc[1], rsp_cyc[0]);
    chk("hold rsp0", rsp_val[0], 32'h1E1E2468);
    chk("hold rsp1", rsp_val[1], 32'h00000002);
    chk("hold ready while busy", busy_ready, 0);
    repeat (4) @(negedge clk);

    // Reset in the middle of a DR shift while tck is high.
    run_cmd(OP_RESET, 6'd0, 32'h0, r_rsp, r_rises, r_npulse, r_lat,
            r_tms, r_tbad, r_held, r_done, r_busy1, r_ready1, r_ready_rsp);
    chk("pre-abort reset response", r_done, 1'b1);
    cmd_op = OP_SHIFT_DR; cmd_len = 6'd32; cmd_data = 32'hFFFFFFFF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    r_rises = 0;
    while (!((r_rises >= 5) && tck) && (guard < 500)) begin
      @(negedge clk);
      if (tck && (guard > 0)) r_rises = r_rises + 1;
      guard++;
      while (tck && (guard < 500) && !((r_rises >= 5))) begin
        @(negedge clk);
        guard++;
      end
    end
    chk("abort reached shift", guard < 500, 1'b1);
    chk("abort tdi before rst", tdi, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort tck", tck, 1'b0);
    chk("abort tms", tms, 1'b1);
    chk("abort tdi", tdi, 1'b0);
    chk("abort cmd_ready", cmd_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    rv_in_rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rv_in_rst++;
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) rv_in_rst++;
    end
    chk("abort no response", rv_in_rst, 0);

    run_cmd(OP_RESET, 6'd0, 32'h0, r_rsp, r_rises, r_npulse, r_lat,
            r_tms, r_tbad, r_held, r_done, r_busy1, r_ready1, r_ready_rsp);
    chk("recover reset rsp", r_rsp, 32'h0);
    chk("recover reset tms", r_tms, 7'b0111111);
    run_cmd(OP_SHIFT_DR, 6'd32, 32'h0, r_rsp, r_rises, r_npulse, r_lat,
            r_tms, r_tbad, r_held, r_done, r_busy1, r_ready1, r_ready_rsp);
    chk("recover idcode", r_rsp, 32'hDEADBEEF);
    chk("recover idcode pulses", r_npulse, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
